// File: rtl/up_counter_pkg.sv
// Shared definitions for the up_counter_tc terminal-count counter.
// Holds the FSM state encoding and the default counter/limit width.
// No ports; imported by up_counter_tc.
package up_counter_pkg;

  // Default width of count and limit, in bits.
  localparam int N_DEFAULT = 10;

  // Control states: IDLE waits for start, RUN counts, DONE holds after a one-shot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : up_counter_pkg

// File: rtl/up_counter_tc.sv
// Start/abort-controlled up counter with a registered terminal-count pulse.
// The counter can run one-shot (stops in DONE) or auto-reload (runs until abort).
// Latency: count, tc, busy and done are all registered, so each changes one clock after the qualifying input cycle.
// Backpressure: there is none. enable only gates counting while in RUN.
// Optional feature: define UP_COUNTER_TC_WRAPCNT_EN to add an 8-bit saturating wrap_cnt output.
//   wrap_cnt counts auto-reload terminal counts.
// Ports:
//   clk      - single clock; all state changes on its rising edge
//   reset    - asynchronous, active-low; deassertion must already be synchronised
//   start    - pulse; begins a run, or restarts one already in RUN; samples limit and mode
//   abort    - pulse; returns to IDLE and has priority over start
//   enable   - advances the count while in RUN
//   mode     - 0 = one-shot, 1 = auto-reload; sampled on start
//   limit    - terminal count, N bits; sampled on start
//   count    - current count, N bits
//   tc       - one-cycle terminal-count pulse
//   busy     - high in RUN
//   done     - high in DONE
//   wrap_cnt - only with UP_COUNTER_TC_WRAPCNT_EN; number of auto-reload wraps, saturating at 255
module up_counter_tc
  import up_counter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         enable,
  input  logic         mode,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
`ifdef UP_COUNTER_TC_WRAPCNT_EN
  ,
  output logic [7:0]   wrap_cnt
`endif
);

  state_t       r_state;
  logic [N-1:0] r_count;
  logic [N-1:0] r_lim;
  logic         r_mode;
  logic         r_tc;

  // An enabled RUN cycle that is not overridden by abort or start.
  logic w_advance;
  logic w_at_lim;

  assign w_advance = (r_state == RUN) && enable && !abort && !start;

  // A count only ever starts at 0 and steps by 1 up to r_lim.
  // Equality is therefore sufficient to detect the terminal count, and the count cannot wrap.
  assign w_at_lim  = (r_count == r_lim);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_lim   <= '0;
      r_mode  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      // tc is a pulse; it is only raised in the terminal-count cycle below.
      r_tc <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (start) begin
        r_state <= RUN;
        r_count <= '0;
        r_lim   <= limit;
        r_mode  <= mode;
      end else if (w_advance) begin
        if (w_at_lim) begin
          r_tc <= 1'b1;
          if (r_mode) begin
            r_count <= '0;
          end else begin
            // One-shot: count stays at the limit while in DONE.
            r_state <= DONE;
          end
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);

`ifdef UP_COUNTER_TC_WRAPCNT_EN
  logic [7:0] r_wrap_cnt;
  logic       w_reload_tc;

  assign w_reload_tc = w_advance && w_at_lim && r_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap_cnt <= 8'd0;
    end else if (abort || start) begin
      r_wrap_cnt <= 8'd0;
    end else if (w_reload_tc && (r_wrap_cnt != 8'hFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule : up_counter_tc
